// File: rtl/rsa_pkg.sv
// rsa_pkg: shared types and default parameters for the RSA arithmetic engine.
//   - Default modulus set: n=79 (7 bits), radix 2^3, p=1, R^2 mod n = 22
//     (R = 2^9, the smallest power of the radix that covers n_bit).
//   - FSM state encodings for mod_exp and mod_mul, plus a debug struct that
//     exposes both states and the internal mod_mul start line.
package rsa_pkg;

  localparam int                   DEF_N_BIT  = 7;
  localparam logic [DEF_N_BIT-1:0] DEF_N      = 7'd79;
  localparam int                   DEF_E_BIT  = 8;
  localparam int                   DEF_LOGR   = 3;
  localparam logic [DEF_LOGR-1:0]  DEF_P      = 3'd1;
  localparam logic [DEF_N_BIT-1:0] DEF_R2MODN = 7'd22;

  typedef enum logic [2:0] {
    ME_IDLE    = 3'd0,
    ME_SQR     = 3'd1,
    ME_SQR_REL = 3'd2,
    ME_MUL     = 3'd3,
    ME_MUL_REL = 3'd4,
    ME_NEXT    = 3'd5,
    ME_DONE    = 3'd6
  } me_state_t;

  typedef enum logic [1:0] {
    MM_IDLE   = 2'd0,
    MM_RUN    = 2'd1,
    MM_ENDING = 2'd2
  } mm_state_t;

  typedef struct packed {
    me_state_t state;
    mm_state_t mm_state;
    logic      mm_start;
  } mod_exp_dbg_t;

endpackage

// File: rtl/mod_exp_if.sv
// mod_exp_if: request/response bundle of the modular-exponentiation engine.
//   start  : level request, sampled by the engine only while idle or done
//   base   : operand (< n), captured together with start
//   exp    : exponent, captured together with start
//   result : base^exp mod n, valid while done=1
//   done   : result is valid; engine waits for start to drop
//   busy   : an exponentiation is in progress
// Handshake: the master raises start with base/exp valid; the engine captures
// them on the first clock it sees start in IDLE and raises busy. When done
// rises, result is valid; holding start high keeps the engine in DONE,
// dropping start returns it to IDLE on the next clock.
interface mod_exp_if import rsa_pkg::*; #(
  parameter int N_BIT = DEF_N_BIT,
  parameter int E_BIT = DEF_E_BIT
);
  logic             start;
  logic [N_BIT-1:0] base;
  logic [E_BIT-1:0] exp;
  logic [N_BIT-1:0] result;
  logic             done;
  logic             busy;

  modport master (output start, base, exp, input result, done, busy);
  modport slave  (input start, base, exp, output result, done, busy);
endinterface

// File: rtl/mod_exp_mul.sv
// mod_mul: z = x*y mod n using two radix-2^LOGR Montgomery passes:
//   pass 0: t = x*y*R^-1 mod n, pass 1: z = t*R2MODN*R^-1 mod n = x*y mod n.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start_i        : level request; x_i/y_i must be stable while it is high
//   x_i, y_i       : operands (< n)
//   z_o            : product mod n, valid while done_o=1
//   done_o         : high in ENDING; leaves ENDING the cycle after start_i drops
//   state_o        : FSM state for observation
module mod_mul import rsa_pkg::*; #(
  parameter int               N_BIT  = DEF_N_BIT,
  parameter logic [N_BIT-1:0] N      = DEF_N,
  parameter int               LOGR   = DEF_LOGR,
  parameter logic [LOGR-1:0]  P      = DEF_P,
  parameter logic [N_BIT-1:0] R2MODN = DEF_R2MODN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [N_BIT-1:0] x_i,
  input  logic [N_BIT-1:0] y_i,
  output logic [N_BIT-1:0] z_o,
  output logic             done_o,
  output mm_state_t        state_o
);
  localparam int K  = (N_BIT + LOGR - 1) / LOGR;  // radix digits per pass
  localparam int XW = K * LOGR;
  localparam int AW = N_BIT + LOGR + 1;            // holds A + x_i*y + q*n
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  mm_state_t        state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [N_BIT-1:0] y_q, y_d;
  logic [N_BIT:0]   a_q, a_d;   // accumulator stays below 2n
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic [N_BIT-1:0] z_q, z_d;

  logic [AW-1:0]    t_sum, t_full;
  logic [LOGR-1:0]  q;
  logic [N_BIT:0]   a_next, a_red;

  // One Montgomery digit step: add x_i*y, add the multiple of n that clears
  // the low LOGR bits, then shift them out.
  always_comb begin
    t_sum  = AW'(a_q) + AW'(x_q[LOGR-1:0]) * AW'(y_q);
    q      = t_sum[LOGR-1:0] * P;
    t_full = t_sum + AW'(q) * AW'(N);
    a_next = (N_BIT+1)'(t_full >> LOGR);
    a_red  = (a_next >= {1'b0, N}) ? (a_next - {1'b0, N}) : a_next;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    z_d     = z_q;
    unique case (state_q)
      MM_IDLE: begin
        if (start_i) begin
          x_d     = XW'(x_i);
          y_d     = y_i;
          a_d     = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
          state_d = MM_RUN;
        end
      end
      MM_RUN: begin
        x_d   = x_q >> LOGR;
        a_d   = a_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(K - 1)) begin
          if (!pass_q) begin
            // Second pass brings the result out of the Montgomery domain.
            x_d    = XW'(a_red);
            y_d    = R2MODN;
            a_d    = '0;
            cnt_d  = '0;
            pass_d = 1'b1;
          end else begin
            z_d     = N_BIT'(a_red);
            state_d = MM_ENDING;
          end
        end
      end
      MM_ENDING: begin
        if (!start_i) state_d = MM_IDLE;
      end
      default: state_d = MM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MM_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      z_q     <= z_d;
    end
  end

  assign z_o     = z_q;
  assign done_o  = (state_q == MM_ENDING);
  assign state_o = state_q;
endmodule

// File: rtl/mod_exp.sv
// mod_exp: result = base^exp mod n by left-to-right binary square-and-multiply,
// sequencing one shared mod_mul through its start/done handshake.
// Every exponent bit is processed (leading zeros square 1, which is harmless),
// so the number of squarings is independent of the exponent value.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (also resets mod_mul)
//   ctrl_if    : slave side of mod_exp_if (start/base/exp in, result/done/busy out)
//   dbg_o      : controller state, mod_mul state and the internal mm_start
module mod_exp import rsa_pkg::*; #(
  parameter int               N_BIT  = DEF_N_BIT,
  parameter logic [N_BIT-1:0] N      = DEF_N,
  parameter int               E_BIT  = DEF_E_BIT,
  parameter int               LOGR   = DEF_LOGR,
  parameter logic [LOGR-1:0]  P      = DEF_P,
  parameter logic [N_BIT-1:0] R2MODN = DEF_R2MODN
) (
  input  logic         clk,
  input  logic         rst_n,
  mod_exp_if.slave     ctrl_if,
  output mod_exp_dbg_t dbg_o
);
  localparam int IW = (E_BIT > 1) ? $clog2(E_BIT) : 1;

  me_state_t        state_q, state_d;
  logic [N_BIT-1:0] base_q, base_d;
  logic [E_BIT-1:0] exp_q, exp_d;
  logic [N_BIT-1:0] acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N_BIT-1:0] mm_x_q, mm_x_d;
  logic [N_BIT-1:0] mm_y_q, mm_y_d;
  logic             mm_start_q, mm_start_d;

  logic [N_BIT-1:0] mm_z;
  logic             mm_done;
  mm_state_t        mm_state;

  mod_mul #(
    .N_BIT  (N_BIT),
    .N      (N),
    .LOGR   (LOGR),
    .P      (P),
    .R2MODN (R2MODN)
  ) u_mod_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mm_start_q),
    .x_i     (mm_x_q),
    .y_i     (mm_y_q),
    .z_o     (mm_z),
    .done_o  (mm_done),
    .state_o (mm_state)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    exp_d      = exp_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    mm_x_d     = mm_x_q;
    mm_y_d     = mm_y_q;
    mm_start_d = mm_start_q;
    unique case (state_q)
      ME_IDLE: begin
        if (ctrl_if.start) begin
          base_d  = ctrl_if.base;
          exp_d   = ctrl_if.exp;
          acc_d   = N_BIT'(1);
          idx_d   = IW'(E_BIT - 1);
          state_d = ME_SQR;
        end
      end
      // Operands are registered and acc/base_r do not change while the
      // multiplier runs, so mm_x/mm_y stay stable for the whole request.
      ME_SQR: begin
        mm_x_d = acc_q;
        mm_y_d = acc_q;
        if (mm_done) begin
          acc_d      = mm_z;
          mm_start_d = 1'b0;
          state_d    = ME_SQR_REL;
        end else begin
          mm_start_d = 1'b1;
        end
      end
      // mod_mul must be seen back in IDLE before the next request is raised.
      ME_SQR_REL: begin
        if (!mm_done) state_d = exp_q[idx_q] ? ME_MUL : ME_NEXT;
      end
      ME_MUL: begin
        mm_x_d = acc_q;
        mm_y_d = base_q;
        if (mm_done) begin
          acc_d      = mm_z;
          mm_start_d = 1'b0;
          state_d    = ME_MUL_REL;
        end else begin
          mm_start_d = 1'b1;
        end
      end
      ME_MUL_REL: begin
        if (!mm_done) state_d = ME_NEXT;
      end
      ME_NEXT: begin
        if (idx_q == '0) begin
          state_d = ME_DONE;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = ME_SQR;
        end
      end
      ME_DONE: begin
        if (!ctrl_if.start) state_d = ME_IDLE;
      end
      default: state_d = ME_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ME_IDLE;
      base_q     <= '0;
      exp_q      <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      mm_x_q     <= '0;
      mm_y_q     <= '0;
      mm_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      exp_q      <= exp_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      mm_x_q     <= mm_x_d;
      mm_y_q     <= mm_y_d;
      mm_start_q <= mm_start_d;
    end
  end

  // acc is only rewritten after the next start, so it doubles as the
  // held result.
  assign ctrl_if.result = acc_q;
  assign ctrl_if.done   = (state_q == ME_DONE);
  assign ctrl_if.busy   = (state_q != ME_IDLE) && (state_q != ME_DONE);

  assign dbg_o.state    = state_q;
  assign dbg_o.mm_state = mm_state;
  assign dbg_o.mm_start = mm_start_q;
endmodule

// File: tb/tb_mod_exp.sv
module tb_mod_exp;
  import rsa_pkg::*;

  logic         clk;
  logic         rst_n;
  mod_exp_dbg_t dbg;

  mod_exp_if bus ();

  mod_exp dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl_if (bus),
    .dbg_o   (dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want $finish before 50000 cycles");
    $fatal(1, "watchdog");
  end

  // Counters and scoreboard
  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];
  int         ops_q[$];
  int         mul_q[$];

  function automatic void check(input string name, input logic [31:0] actual,
                                input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, actual, required);
    end
  endfunction

  // Monitor: counts mod_mul requests and compares on each rising done.
  int   ops_cnt  = 0;
  int   mul_cnt  = 0;
  logic prev_done = 1'b0;
  logic prev_mms  = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ops_cnt   = 0;
      mul_cnt   = 0;
      prev_done = 1'b0;
      prev_mms  = 1'b0;
    end else begin
      if (dbg.mm_start && !prev_mms) begin
        ops_cnt++;
        if (dbg.state == ME_MUL) mul_cnt++;
      end
      if (bus.done && !prev_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          check("result", bus.result, exp_q.pop_front());
          check("op_count", ops_cnt, ops_q.pop_front());
          check("mul_count", mul_cnt, mul_q.pop_front());
        end
        ops_cnt = 0;
        mul_cnt = 0;
      end
      prev_done = bus.done;
      prev_mms  = dbg.mm_start;
    end
  end

  // Driver: one exponentiation; hold>0 keeps start high that many cycles in DONE.
  task automatic run_op(input logic [6:0] b, input logic [7:0] e,
                        input logic [6:0] res, input int ops, input int muls,
                        input int hold, output int lat);
    int   cyc;
    logic stable;
    bus.base  = b;
    bus.exp   = e;
    exp_q.push_back(res);
    ops_q.push_back(ops);
    mul_q.push_back(muls);
    bus.start = 1'b1;
    @(posedge clk); #1;
    check("busy_after_start", bus.busy, 1);
    if (hold == 0) bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("done_within_budget", bus.done, 1);
    lat = cyc + 1;  // includes the cycle start was presented in
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        if (!bus.done || bus.busy || bus.result !== res) stable = 1'b0;
      end
      check("done_hold_stable", stable, 1);
      check("no_new_op_in_hold", ops_cnt, 0);
      bus.start = 1'b0;
    end
    @(posedge clk); #1;
    check("done_low_after_drop", bus.done, 0);
    check("idle_after_drop", dbg.state, ME_IDLE);
  endtask

  int lat0, lat_a, lat_b, per_op;
  int wait_cyc;

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.base  = '0;
    bus.exp   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_result", bus.result, 0);
    check("rst_state", dbg.state, ME_IDLE);
    check("rst_mm_start", dbg.mm_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // exp=0: eight squarings only; calibrates the per-op cost.
    run_op(7'd17, 8'd0, 7'd1, 8, 0, 0, lat0);
    check("lat_per_op_integral", (lat0 - 10) % 8, 0);
    per_op = (lat0 - 10) / 8;

    run_op(7'd5, 8'd3, 7'd46, 10, 2, 0, lat_a);
    check("latency_5_3", lat_a, 10 * per_op + 10);

    run_op(7'd0, 8'd5, 7'd0, 10, 2, 0, lat_b);
    check("latency_0_5", lat_b, 10 * per_op + 10);

    run_op(7'd3, 8'd78, 7'd1, 12, 4, 0, lat_b);
    check("latency_3_78", lat_b, 12 * per_op + 10);

    run_op(7'd2, 8'hFF, 7'd18, 16, 8, 0, lat_b);
    check("latency_2_ff", lat_b, 16 * per_op + 10);

    // Start held through DONE for 20 cycles.
    run_op(7'd5, 8'd3, 7'd46, 10, 2, 20, lat_b);
    check("latency_hold", lat_b, 10 * per_op + 10);

    // Reset during the third multiply.
    bus.base  = 7'd2;
    bus.exp   = 8'hFF;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_cyc  = 0;
    while (mul_cnt < 3 && wait_cyc < 2000) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    check("third_mul_reached", dbg.state, ME_MUL);
    rst_n = 1'b0;
    #1;
    check("abort_done", bus.done, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_result", bus.result, 0);
    check("abort_state", dbg.state, ME_IDLE);
    check("abort_mm_start", dbg.mm_start, 0);
    check("abort_mm_state", dbg.mm_state, MM_IDLE);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(7'd5, 8'd3, 7'd46, 10, 2, 0, lat_b);
    check("latency_after_abort", lat_b, 10 * per_op + 10);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
